// File: rtl/eka_mem_arbiter.sv
// Round-robin arbiter that lets the fetch and load/store ports share one single-ported
// memory, one transaction at a time. Define EKA_ARB_STATS_EN to add grant/conflict counters.
module eka_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  input  logic                  m_ready,
  input  logic                  m_rvalid,
  input  logic [31:0]           m_rdata
`ifdef EKA_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  i_grant_cnt,
  output logic [CNT_WIDTH-1:0]  d_grant_cnt,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {INST = 1'b0, DATA = 1'b1} port_t;

  state_t state, state_next;
  port_t  owner, last_grant;
  logic   grant_i, grant_d;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (i_req && d_req) begin
          grant_i = (last_grant == DATA);
          grant_d = (last_grant == INST);
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (i_req || d_req) state_next = ISSUE;
      end
      ISSUE:   if (m_ready)  state_next = WAIT;
      WAIT:    if (m_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= INST;
      last_grant <= INST;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      state <= state_next;
      m_req <= (state_next == ISSUE);
      if (grant_i) begin
        owner      <= INST;
        last_grant <= INST;
        m_we       <= 1'b0;
        m_addr     <= i_addr;
        m_wdata    <= '0;
      end else if (grant_d) begin
        owner      <= DATA;
        last_grant <= DATA;
        m_we       <= d_we;
        m_addr     <= d_addr;
        m_wdata    <= d_wdata;
      end
    end
  end

  // Responses outside WAIT are strays and never reach a requester.
  assign i_rvalid = m_rvalid && (state == WAIT) && (owner == INST);
  assign d_rvalid = m_rvalid && (state == WAIT) && (owner == DATA);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

`ifdef EKA_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant_i) i_grant_cnt <= i_grant_cnt + 1'b1;
      if (grant_d) d_grant_cnt <= d_grant_cnt + 1'b1;
      if (state == IDLE && i_req && d_req) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`else
  logic [CNT_WIDTH-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_eka_mem_arbiter.sv
// Bench for eka_mem_arbiter: directed protocol scenarios plus a randomized run scored
// against a transaction-level round-robin model and a bench-side memory.
module tb_eka_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ready, m_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_rvalid, d_rvalid, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
`ifdef EKA_ARB_STATS_EN
  logic [3:0]  i_grant_cnt, d_grant_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [logic [31:0]];

  eka_mem_arbiter #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef EKA_ARB_STATS_EN
    , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are observed on the falling edge.
  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_we = 0; m_ready = 0; m_rvalid = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
  endtask

  task automatic apply_reset();
    start_cycle(); reset = 1; idle_inputs();
    start_cycle();
    start_cycle(); reset = 0;
  endtask

  task automatic test_reset();
    start_cycle(); m_rvalid = 1; m_rdata = 32'hA5A5_A5A5;
    mid_cycle();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req got %b exp 0", m_req); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rst_m_we got %b exp 0", m_we); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr got %h exp 0", m_addr); end
    checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_wdata got %h exp 0", m_wdata); end
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {i_rvalid, d_rvalid}); end
`ifdef EKA_ARB_STATS_EN
    checks++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 12'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", {i_grant_cnt, d_grant_cnt, conflict_cnt}); end
`endif
    start_cycle(); reset = 0; m_rvalid = 0;
    mid_cycle();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_release_m_req got %b exp 0", m_req); end
  endtask

  task automatic test_fetch_only();
    apply_reset();
    start_cycle(); i_req = 1; i_addr = 32'h10; m_ready = 1;
    mid_cycle();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fetch_c0_m_req got %b exp 0", m_req); end
    start_cycle();
    mid_cycle();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fetch_c1_m_req got %b exp 1", m_req); end
    checks++; if (m_addr !== 32'h10) begin errors++; $display("FAIL fetch_c1_m_addr got %h exp 10", m_addr); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL fetch_c1_m_we got %b exp 0", m_we); end
    start_cycle(); m_rvalid = 1; m_rdata = 32'h1234_5678;
    mid_cycle();
    checks++; if ({i_rvalid, d_rvalid} !== 2'b10) begin errors++; $display("FAIL fetch_c2_rvalid got %b exp 10", {i_rvalid, d_rvalid}); end
    checks++; if (i_rdata !== 32'h1234_5678) begin errors++; $display("FAIL fetch_c2_rdata got %h exp 12345678", i_rdata); end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fetch_c2_m_req got %b exp 0", m_req); end
    start_cycle(); i_req = 0; m_rvalid = 0;
    mid_cycle();
    checks++; if ({i_rvalid, d_rvalid, m_req} !== 3'b000) begin errors++; $display("FAIL fetch_c3_quiet got %b exp 000", {i_rvalid, d_rvalid, m_req}); end
  endtask

  task automatic test_tie_order();
    int gap;
    bit want_data;
    apply_reset();
    start_cycle(); i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200; d_we = 0; m_ready = 1;
    for (int k = 0; k < 4; k++) begin
      want_data = (k % 2 == 0);
      gap = 0;
      mid_cycle();
      while (!m_req && gap < 10) begin start_cycle(); mid_cycle(); gap++; end
      checks++; if (gap !== 1) begin errors++; $display("FAIL tie_gap%0d got %0d exp 1", k, gap); end
      checks++; if (m_addr !== (want_data ? 32'h200 : 32'h100)) begin errors++; $display("FAIL tie_addr%0d got %h exp %h", k, m_addr, want_data ? 32'h200 : 32'h100); end
      start_cycle(); m_rvalid = 1; m_rdata = 32'hC0DE_0000 + k;
      mid_cycle();
      checks++; if ({d_rvalid, i_rvalid} !== {want_data, !want_data}) begin errors++; $display("FAIL tie_rvalid%0d got %b exp %b", k, {d_rvalid, i_rvalid}, {want_data, !want_data}); end
      start_cycle(); m_rvalid = 0;
    end
    i_req = 0; d_req = 0; m_ready = 0;
  endtask

  task automatic test_store_backpressure();
    int accepts = 0;
    apply_reset();
    start_cycle(); d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; m_ready = 0;
    for (int c = 1; c <= 3; c++) begin
      start_cycle();
      mid_cycle();
      checks++; if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_hold%0d got %b %b %h %h exp 1 1 20 deadbeef", c, m_req, m_we, m_addr, m_wdata); end
    end
    start_cycle(); m_ready = 1;
    mid_cycle(); if (m_req && m_ready) accepts++;
    start_cycle(); m_rvalid = 1; m_rdata = 32'h0;
    mid_cycle(); if (m_req && m_ready) accepts++;
    checks++; if (accepts !== 1) begin errors++; $display("FAIL store_accepts got %0d exp 1", accepts); end
    checks++; if ({d_rvalid, i_rvalid} !== 2'b10) begin errors++; $display("FAIL store_ack got %b exp 10", {d_rvalid, i_rvalid}); end
    start_cycle(); d_req = 0; d_we = 0; m_rvalid = 0; m_ready = 0;
    mid_cycle();
    checks++; if ({d_rvalid, m_req} !== 2'b00) begin errors++; $display("FAIL store_done got %b exp 00", {d_rvalid, m_req}); end
  endtask

  task automatic test_stray();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      start_cycle(); m_rvalid = 1; m_rdata = $urandom();
      mid_cycle();
      checks++; if ({i_rvalid, d_rvalid, m_req} !== 3'b000) begin errors++; $display("FAIL stray_idle%0d got %b exp 000", c, {i_rvalid, d_rvalid, m_req}); end
    end
    start_cycle(); m_rvalid = 0; i_req = 1; i_addr = 32'h44; m_ready = 0;
    start_cycle(); m_rvalid = 1;
    mid_cycle();
    checks++; if ({m_req, m_addr} !== {1'b1, 32'h44}) begin errors++; $display("FAIL stray_then_grant got %b %h exp 1 44", m_req, m_addr); end
    checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL stray_issue got %b exp 0", i_rvalid); end
    start_cycle(); m_rvalid = 0; m_ready = 1;
    start_cycle(); m_rvalid = 1; m_ready = 0;
    mid_cycle();
    checks++; if (i_rvalid !== 1'b1) begin errors++; $display("FAIL stray_recover got %b exp 1", i_rvalid); end
    start_cycle(); i_req = 0; m_rvalid = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_cycle(); i_req = 1; i_addr = 32'h30; m_ready = 0;
    start_cycle();
    mid_cycle();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rmid_issue got %b exp 1", m_req); end
    start_cycle(); reset = 1; i_req = 0;
    #1;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rmid_async_drop got %b exp 0", m_req); end
    start_cycle(); reset = 0;
    // Now reset while waiting for the response, then deliver it late.
    start_cycle(); i_req = 1; m_ready = 1;
    start_cycle();
    start_cycle(); reset = 1; i_req = 0; m_ready = 0;
    #1;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rmid_wait_m_req got %b exp 0", m_req); end
    start_cycle(); reset = 0; m_rvalid = 1;
    mid_cycle();
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL rmid_late_rvalid got %b exp 00", {i_rvalid, d_rvalid}); end
    start_cycle(); m_rvalid = 0; i_req = 1; i_addr = 32'h34; m_ready = 1;
    start_cycle();
    mid_cycle();
    checks++; if ({m_req, m_addr} !== {1'b1, 32'h34}) begin errors++; $display("FAIL rmid_next_fetch got %b %h exp 1 34", m_req, m_addr); end
    start_cycle(); m_rvalid = 1;
    mid_cycle();
    checks++; if (i_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_next_rvalid got %b exp 1", i_rvalid); end
    start_cycle(); i_req = 0; m_rvalid = 0; m_ready = 0;
  endtask

`ifdef EKA_ARB_STATS_EN
  task automatic test_stats();
    int done = 0;
    bit pend = 0;
    apply_reset();
    for (int c = 0; c < 120 && done < 17; c++) begin
      start_cycle(); i_req = 1; m_ready = 1; m_rvalid = pend; pend = 0;
      mid_cycle();
      if (i_rvalid) done++;
      if (m_req && m_ready) pend = 1;
    end
    start_cycle(); i_req = 0; m_rvalid = 0; m_ready = 0;
    start_cycle();
    mid_cycle();
    checks++; if (done !== 17) begin errors++; $display("FAIL stats_fetches got %0d exp 17", done); end
    checks++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 12'h100) begin errors++; $display("FAIL stats_wrap got %h exp 100", {i_grant_cnt, d_grant_cnt, conflict_cnt}); end
    apply_reset();
    start_cycle(); i_req = 1; d_req = 1; m_ready = 1;
    start_cycle();
    start_cycle(); m_rvalid = 1;
    start_cycle(); m_rvalid = 0;
    start_cycle(); d_req = 0;
    start_cycle(); m_rvalid = 1;
    start_cycle(); m_rvalid = 0; i_req = 0; m_ready = 0;
    mid_cycle();
    checks++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 12'h112) begin errors++; $display("FAIL stats_conflict got %h exp 112", {i_grant_cnt, d_grant_cnt, conflict_cnt}); end
  endtask
`endif

  // Transaction-level model: the arbiter is free from the cycle after each response;
  // in a free cycle the requesting port wins, and a tie goes to the port not served last.
  task automatic test_random();
    bit ni_req = 0, nd_req = 0, nd_we = 0;
    logic [31:0] ni_addr = 0, nd_addr = 0, nd_wdata = 0;
    bit free = 1, issuing = 0, outstanding = 0, last_data = 0, rsp_port = 0, w_port;
    int free_cyc = 0, resp_cyc = 0, served = 0, wait_i = 0, wait_d = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, rsp_data = 0;
    logic e_we = 0;
    apply_reset();
    for (int t = 0; t < 600; t++) begin
      start_cycle();
      i_req = ni_req; i_addr = ni_addr;
      d_req = nd_req; d_we = nd_we; d_addr = nd_addr; d_wdata = nd_wdata;
      m_ready = ($urandom_range(0, 3) != 0);
      m_rvalid = outstanding && (t == resp_cyc);
      m_rdata = m_rvalid ? rsp_data : $urandom();
      mid_cycle();
      checks++; if ({i_rvalid, d_rvalid} !== {m_rvalid && !rsp_port, m_rvalid && rsp_port}) begin errors++; $display("FAIL rnd_rvalid t=%0d got %b exp %b", t, {i_rvalid, d_rvalid}, {m_rvalid && !rsp_port, m_rvalid && rsp_port}); end
      if (m_rvalid) begin
        checks++; if ((rsp_port ? d_rdata : i_rdata) !== rsp_data) begin errors++; $display("FAIL rnd_rdata t=%0d got %h exp %h", t, rsp_port ? d_rdata : i_rdata, rsp_data); end
        outstanding = 0; free = 1; free_cyc = t + 1; served++;
        if (rsp_port) begin nd_req = 0; wait_d = 0; end else begin ni_req = 0; wait_i = 0; end
      end
      checks++; if (m_req !== issuing) begin errors++; $display("FAIL rnd_m_req t=%0d got %b exp %b", t, m_req, issuing); end
      if (m_req && m_ready) begin
        checks++; if (outstanding) begin errors++; $display("FAIL rnd_overlap t=%0d got 2 outstanding exp 1", t); end
        checks++; if ({m_addr, m_we, m_wdata} !== {e_addr, e_we, e_wdata}) begin errors++; $display("FAIL rnd_txn t=%0d got %h %b %h exp %h %b %h", t, m_addr, m_we, m_wdata, e_addr, e_we, e_wdata); end
        if (e_we) begin mem[e_addr] = e_wdata; rsp_data = $urandom(); end
        else rsp_data = mem.exists(e_addr) ? mem[e_addr] : ~e_addr;
        outstanding = 1; issuing = 0; resp_cyc = t + $urandom_range(1, 3);
      end
      if (free && t >= free_cyc && (i_req || d_req)) begin
        w_port = (i_req && d_req) ? !last_data : d_req;
        last_data = w_port; rsp_port = w_port; free = 0; issuing = 1;
        e_addr = w_port ? d_addr : i_addr;
        e_we = w_port ? d_we : 1'b0;
        e_wdata = w_port ? d_wdata : 32'h0;
      end
      if (!ni_req && $urandom_range(0, 2) == 0) begin ni_req = 1; ni_addr = 32'($urandom_range(0, 15)) << 2; end
      if (!nd_req && $urandom_range(0, 2) == 0) begin
        nd_req = 1; nd_we = $urandom_range(0, 1) == 1; nd_wdata = $urandom() | 32'h1;
        nd_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (i_req) wait_i++;
      if (d_req) wait_d++;
      if (wait_i > 60 || wait_d > 60) begin
        checks++; errors++; $display("FAIL rnd_starve t=%0d got wait %0d/%0d exp <=60", t, wait_i, wait_d);
        break;
      end
    end
    checks++; if (served < 40) begin errors++; $display("FAIL rnd_served got %0d exp >=40", served); end
    start_cycle(); idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_tie_order();
    test_store_backpressure();
    test_stray();
    test_reset_mid();
`ifdef EKA_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
